// File: rtl/ccd_readout_seq.sv
// ============================================================================
// ccd_readout_seq
// ----------------------------------------------------------------------------
// Purpose:
//   Clock sequencer for a KAF-style full-frame CCD and its analog front end.
//   One state per rising clk. A frame is NL lines. Each line is VB vertical
//   transfer groups followed by NP binned pixels. Binning is done in the
//   charge domain: extra horizontal shifts (X1/X0 pairs) and repeated
//   vertical groups are inserted before each sample. No divider is needed
//   to find NP/NL. The block tracks the raw CCD position and ends the
//   line/frame once the next step would reach the register length.
//
// Ports:
//   clk, rst                 sequencer clock, async active-high reset
//   start, abort             frame start (IDLE only) / unconditional stop
//   mode[1:0]                0 idle, 1 clean, 2 readout 1x1, 3 readout binned
//   hbin[2:0], vbin[2:0]     horizontal / vertical bin factors (0 acts as 1)
//   ad_cdsclk1, ad_cdsclk2,
//   ad_adclk, ad_oeb_n       AFE controls, decoded from state
//   kaf_r, kaf_h1, kaf_v1,
//   kaf_v2, kaf_amp          CCD clocks, decoded from state
//   busy                     frame in progress
//   pix_valid                strobe for the sample cycle of each binned pixel
//   pix_x, pix_y [CW-1:0]    binned coordinates of the strobed pixel
//   frame_done               one-cycle pulse after a completed frame
// ============================================================================
module ccd_readout_seq #(
   parameter int H_REGS = 2184,
   parameter int V_REGS = 1472,
   parameter int CW     = 12
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   input  logic          abort,
   input  logic [1:0]    mode,
   input  logic [2:0]    hbin,
   input  logic [2:0]    vbin,
   output logic          ad_cdsclk1,
   output logic          ad_cdsclk2,
   output logic          ad_adclk,
   output logic          ad_oeb_n,
   output logic          kaf_r,
   output logic          kaf_h1,
   output logic          kaf_v1,
   output logic          kaf_v2,
   output logic          kaf_amp,
   output logic          busy,
   output logic          pix_valid,
   output logic [CW-1:0] pix_x,
   output logic [CW-1:0] pix_y,
   output logic          frame_done
);

   localparam logic [CW:0] H_LIM_C = (CW+1)'(H_REGS);
   localparam logic [CW:0] V_LIM_C = (CW+1)'(V_REGS);

   typedef enum logic [4:0] {
      ST_IDLE = 5'd0,
      ST_V0   = 5'd1,
      ST_V1   = 5'd2,
      ST_V2   = 5'd3,
      ST_V3   = 5'd4,
      ST_V4   = 5'd5,
      ST_P0   = 5'd6,
      ST_P1   = 5'd7,
      ST_P2   = 5'd8,
      ST_P3   = 5'd9,
      ST_P4   = 5'd10,
      ST_P5   = 5'd11,
      ST_X1   = 5'd12,
      ST_X0   = 5'd13,
      ST_P6   = 5'd14,
      ST_P7   = 5'd15,
      ST_P8   = 5'd16,
      ST_P9   = 5'd17
   } state_t;

   // Effective bin factor. Modes 1 and 2 are unbinned. A factor of zero means one.
   function automatic logic [2:0] eff_bin(input logic [1:0] m, input logic [2:0] f);
      logic [2:0] r;
      if ((m == 2'd1) || (m == 2'd2)) begin
         r = 3'd1;
      end else if (f == 3'd0) begin
         r = 3'd1;
      end else begin
         r = f;
      end
      return r;
   endfunction

   state_t        state_r;
   state_t        state_nxt_s;
   logic [1:0]    mode_r;
   logic [2:0]    hb_r;
   logic [2:0]    vb_r;
   logic [2:0]    vgrp_r;
   logic [2:0]    xcnt_r;
   logic [CW-1:0] pix_x_r;
   logic [CW-1:0] pix_y_r;
   logic [CW-1:0] h_pos_r;
   logic [CW-1:0] v_pos_r;
   logic          frame_done_r;

   logic [CW:0]   h_sum_s;
   logic [CW:0]   v_sum_s;
   logic          last_pix_s;
   logic          last_line_s;
   logic          last_vgrp_s;
   logic          last_x_s;
   logic          start_ok_s;
   logic          frame_end_s;

   // Decoded (pre-mode-override) output set
   logic          cds1_s, cds2_s, adclk_s, oeb_dec_s, oeb_s;
   logic          r_s, h1_s, v1_s, v2_s;

   // Raw CCD position after the next binned step. It reaching the register
   // length marks the last pixel / line (equivalent to ceil division).
   assign h_sum_s     = {1'b0, h_pos_r} + {{(CW-2){1'b0}}, hb_r};
   assign v_sum_s     = {1'b0, v_pos_r} + {{(CW-2){1'b0}}, vb_r};
   assign last_pix_s  = (h_sum_s >= H_LIM_C);
   assign last_line_s = (v_sum_s >= V_LIM_C);
   assign last_vgrp_s = (vgrp_r == (vb_r - 3'd1));
   assign last_x_s    = ((xcnt_r + 3'd2) == hb_r);
   assign start_ok_s  = start && (mode != 2'd0);
   assign frame_end_s = (state_r == ST_P9) && last_pix_s && last_line_s && !abort;

   // Next-state logic; abort overrides every transition
   always_comb begin
      state_nxt_s = state_r;
      if (abort) begin
         state_nxt_s = ST_IDLE;
      end else begin
         case (state_r)
            ST_IDLE: begin
               if (start_ok_s) begin
                  state_nxt_s = ST_V0;
               end else begin
                  state_nxt_s = ST_IDLE;
               end
            end
            ST_V0: state_nxt_s = ST_V1;
            ST_V1: state_nxt_s = ST_V2;
            ST_V2: state_nxt_s = ST_V3;
            ST_V3: state_nxt_s = ST_V4;
            ST_V4: begin
               if (last_vgrp_s) begin
                  state_nxt_s = ST_P0;
               end else begin
                  state_nxt_s = ST_V0;
               end
            end
            ST_P0: state_nxt_s = ST_P1;
            ST_P1: state_nxt_s = ST_P2;
            ST_P2: state_nxt_s = ST_P3;
            ST_P3: state_nxt_s = ST_P4;
            ST_P4: state_nxt_s = ST_P5;
            ST_P5: begin
               if (hb_r > 3'd1) begin
                  state_nxt_s = ST_X1;
               end else begin
                  state_nxt_s = ST_P6;
               end
            end
            ST_X1: state_nxt_s = ST_X0;
            ST_X0: begin
               if (last_x_s) begin
                  state_nxt_s = ST_P6;
               end else begin
                  state_nxt_s = ST_X1;
               end
            end
            ST_P6: state_nxt_s = ST_P7;
            ST_P7: state_nxt_s = ST_P8;
            ST_P8: state_nxt_s = ST_P9;
            ST_P9: begin
               if (!last_pix_s) begin
                  state_nxt_s = ST_P0;
               end else if (last_line_s) begin
                  state_nxt_s = ST_IDLE;
               end else begin
                  state_nxt_s = ST_V0;
               end
            end
            default: state_nxt_s = ST_IDLE;
         endcase
      end
   end

   // State, latched configuration, position counters and frame_done pulse
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_r      <= ST_IDLE;
         mode_r       <= 2'd0;
         hb_r         <= 3'd0;
         vb_r         <= 3'd0;
         vgrp_r       <= 3'd0;
         xcnt_r       <= 3'd0;
         pix_x_r      <= '0;
         pix_y_r      <= '0;
         h_pos_r      <= '0;
         v_pos_r      <= '0;
         frame_done_r <= 1'b0;
      end else begin
         state_r      <= state_nxt_s;
         frame_done_r <= frame_end_s;
         if ((state_r == ST_IDLE) && start_ok_s && !abort) begin
            mode_r  <= mode;
            hb_r    <= eff_bin(mode, hbin);
            vb_r    <= eff_bin(mode, vbin);
            vgrp_r  <= 3'd0;
            xcnt_r  <= 3'd0;
            pix_x_r <= '0;
            pix_y_r <= '0;
            h_pos_r <= '0;
            v_pos_r <= '0;
         end else if (!abort) begin
            case (state_r)
               ST_V4: begin
                  if (last_vgrp_s) begin
                     // Line body starts: horizontal position restarts
                     vgrp_r  <= 3'd0;
                     pix_x_r <= '0;
                     h_pos_r <= '0;
                  end else begin
                     vgrp_r  <= vgrp_r + 3'd1;
                  end
               end
               ST_X0: begin
                  if (last_x_s) begin
                     xcnt_r <= 3'd0;
                  end else begin
                     xcnt_r <= xcnt_r + 3'd1;
                  end
               end
               ST_P9: begin
                  if (!last_pix_s) begin
                     pix_x_r <= pix_x_r + {{(CW-1){1'b0}}, 1'b1};
                     h_pos_r <= h_sum_s[CW-1:0];
                  end else if (!last_line_s) begin
                     pix_y_r <= pix_y_r + {{(CW-1){1'b0}}, 1'b1};
                     v_pos_r <= v_sum_s[CW-1:0];
                  end else begin
                     pix_y_r <= pix_y_r;
                  end
               end
               default: begin
                  vgrp_r <= vgrp_r;
               end
            endcase
         end else begin
            vgrp_r <= vgrp_r;
         end
      end
   end

   // CCD/AFE decode straight from the state register
   always_comb begin
      cds1_s    = 1'b0;
      cds2_s    = 1'b0;
      adclk_s   = 1'b0;
      oeb_dec_s = 1'b0;
      r_s       = 1'b0;
      h1_s      = 1'b0;
      v1_s      = 1'b0;
      v2_s      = 1'b0;
      case (state_r)
         ST_IDLE: begin adclk_s = 1'b1; oeb_dec_s = 1'b1; end
         ST_V0:   begin adclk_s = 1'b1; oeb_dec_s = 1'b1; end
         ST_V1:   begin adclk_s = 1'b1; oeb_dec_s = 1'b1; v2_s = 1'b1; end
         ST_V2:   begin adclk_s = 1'b1; oeb_dec_s = 1'b1; v1_s = 1'b1; end
         ST_V3:   begin adclk_s = 1'b1; oeb_dec_s = 1'b1; v2_s = 1'b1; end
         ST_V4:   begin adclk_s = 1'b1; oeb_dec_s = 1'b1; end
         ST_P0:   begin adclk_s = 1'b1; r_s = 1'b1; h1_s = 1'b1; end
         ST_P1:   begin adclk_s = 1'b1; h1_s = 1'b1; end
         ST_P2:   begin cds1_s = 1'b1; h1_s = 1'b1; end
         ST_P3:   h1_s = 1'b1;
         ST_P4:   h1_s = 1'b1;
         ST_P5:   h1_s = 1'b0;
         ST_X1:   h1_s = 1'b1;
         ST_X0:   h1_s = 1'b0;
         ST_P6:   cds2_s = 1'b1;
         ST_P7:   begin adclk_s = 1'b1; cds2_s = 1'b1; end
         ST_P8:   begin adclk_s = 1'b1; cds2_s = 1'b1; end
         ST_P9:   adclk_s = 1'b1;
         default: begin adclk_s = 1'b1; oeb_dec_s = 1'b1; end
      endcase
   end

   // Clean mode never lets the AFE drive its outputs
   always_comb begin
      oeb_s = 1'b0;
      if (mode_r == 2'd1) begin
         oeb_s = 1'b1;
      end else begin
         oeb_s = oeb_dec_s;
      end
   end

   assign ad_cdsclk1 = cds1_s;
   assign ad_cdsclk2 = cds2_s;
   assign ad_adclk   = adclk_s;
   assign ad_oeb_n   = oeb_s;
   assign kaf_r      = r_s;
   assign kaf_h1     = h1_s;
   assign kaf_v1     = v1_s;
   assign kaf_v2     = v2_s;
   assign busy       = (state_r != ST_IDLE);
   // mode_r[1] set means a readout mode (2 or 3)
   assign kaf_amp    = (state_r != ST_IDLE) && mode_r[1];
   assign pix_valid  = (state_r == ST_P9) && mode_r[1];
   assign pix_x      = pix_x_r;
   assign pix_y      = pix_y_r;
   assign frame_done = frame_done_r;

endmodule

// File: tb/tb_ccd_readout_seq.sv
// ============================================================================
// tb_ccd_readout_seq
// ----------------------------------------------------------------------------
// Directed bench for ccd_readout_seq with a 5x4 CCD. Each scenario task
// drives its own stimulus and compares observed counts/levels against
// hand-computed values. Outputs are sampled on the falling clock edge.
// ============================================================================
module tb_ccd_readout_seq;

   localparam int CW = 12;

   logic          clk;
   logic          rst;
   logic          start;
   logic          abort;
   logic [1:0]    mode;
   logic [2:0]    hbin;
   logic [2:0]    vbin;
   logic          ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n;
   logic          kaf_r, kaf_h1, kaf_v1, kaf_v2, kaf_amp;
   logic          busy, pix_valid, frame_done;
   logic [CW-1:0] pix_x, pix_y;

   int checks = 0;
   int errors = 0;

   // Per-frame measurements filled by run_frame
   int m_busy, m_pv, m_fd, m_r, m_adclk, m_cds1, m_cds2, m_oeb_low;
   int m_amp_hi, m_v1, m_h1_rise, m_h1_hi, m_pos_err, m_end_y;

   ccd_readout_seq #(.H_REGS(5), .V_REGS(4), .CW(CW)) dut (
      .clk(clk), .rst(rst), .start(start), .abort(abort), .mode(mode),
      .hbin(hbin), .vbin(vbin),
      .ad_cdsclk1(ad_cdsclk1), .ad_cdsclk2(ad_cdsclk2), .ad_adclk(ad_adclk),
      .ad_oeb_n(ad_oeb_n), .kaf_r(kaf_r), .kaf_h1(kaf_h1), .kaf_v1(kaf_v1),
      .kaf_v2(kaf_v2), .kaf_amp(kaf_amp), .busy(busy), .pix_valid(pix_valid),
      .pix_x(pix_x), .pix_y(pix_y), .frame_done(frame_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts a frame and measures it until the first IDLE cycle, plus 3 more.
   task automatic run_frame(input logic [1:0] m, input logic [2:0] hb,
                            input logic [2:0] vb, input int np);
      int   ex, ey;
      logic prev_h1, seen, done;
      m_busy = 0; m_pv = 0; m_fd = 0; m_r = 0; m_adclk = 0; m_cds1 = 0;
      m_cds2 = 0; m_oeb_low = 0; m_amp_hi = 0; m_v1 = 0; m_h1_rise = 0;
      m_h1_hi = 0; m_pos_err = 0;
      ex = 0; ey = 0; prev_h1 = 1'b0; seen = 1'b0; done = 1'b0;
      mode = m; hbin = hb; vbin = vb; start = 1'b1;
      for (int i = 0; i < 3000 && !done; i++) begin
         @(negedge clk);
         start = 1'b0;
         if (busy) begin
            seen = 1'b1;
            m_busy++;
            if (ad_adclk)        m_adclk++;
            if (ad_cdsclk1)      m_cds1++;
            if (ad_cdsclk2)      m_cds2++;
            if (!ad_oeb_n)       m_oeb_low++;
            if (kaf_amp)         m_amp_hi++;
            if (kaf_r)           m_r++;
            if (kaf_v1)          m_v1++;
            if (kaf_h1)          m_h1_hi++;
            if (kaf_h1 && !prev_h1) m_h1_rise++;
         end
         prev_h1 = kaf_h1;
         if (pix_valid) begin
            m_pv++;
            if (pix_x !== 12'(ex) || pix_y !== 12'(ey)) m_pos_err++;
            ex++;
            if (ex == np) begin
               ex = 0;
               ey++;
            end
         end
         if (frame_done) m_fd++;
         if (!busy && seen) done = 1'b1;
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_timeout: frame did not end, busy=%0b required 0", busy);
      end
      repeat (3) begin
         @(negedge clk);
         if (frame_done) m_fd++;
      end
      m_end_y = ey;
   endtask

   task automatic test_reset();
      rst = 1'b1; start = 1'b0; abort = 1'b0; mode = 2'd0; hbin = 3'd0; vbin = 3'd0;
      repeat (2) @(negedge clk);
      checks++;
      if ({ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n, kaf_r, kaf_h1, kaf_v1,
           kaf_v2, kaf_amp, busy, pix_valid, frame_done} !== 12'b0011_0000_0000) begin
         errors++;
         $display("FAIL reset_outputs: got %b required 001100000000",
                  {ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n, kaf_r, kaf_h1, kaf_v1,
                   kaf_v2, kaf_amp, busy, pix_valid, frame_done});
      end
      checks++;
      if (pix_x !== 12'd0 || pix_y !== 12'd0) begin
         errors++;
         $display("FAIL reset_coords: got x=%0d y=%0d required 0 0", pix_x, pix_y);
      end
      rst = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_mode2();
      run_frame(2'd2, 3'd0, 3'd0, 5);
      checks++; if (m_busy !== 220)   begin errors++; $display("FAIL m2_busy: got %0d required 220", m_busy); end
      checks++; if (m_pv !== 20)      begin errors++; $display("FAIL m2_pix_valid: got %0d required 20", m_pv); end
      checks++; if (m_pos_err !== 0)  begin errors++; $display("FAIL m2_coords: got %0d bad required 0", m_pos_err); end
      checks++; if (m_end_y !== 4)    begin errors++; $display("FAIL m2_lines: got %0d required 4", m_end_y); end
      checks++; if (m_fd !== 1)       begin errors++; $display("FAIL m2_frame_done: got %0d required 1", m_fd); end
      checks++; if (m_r !== 20)       begin errors++; $display("FAIL m2_kaf_r: got %0d required 20", m_r); end
      checks++; if (m_adclk !== 120)  begin errors++; $display("FAIL m2_adclk: got %0d required 120", m_adclk); end
      checks++; if (m_cds1 !== 20)    begin errors++; $display("FAIL m2_cds1: got %0d required 20", m_cds1); end
      checks++; if (m_cds2 !== 60)    begin errors++; $display("FAIL m2_cds2: got %0d required 60", m_cds2); end
      checks++; if (m_oeb_low !== 200) begin errors++; $display("FAIL m2_oeb_low: got %0d required 200", m_oeb_low); end
      checks++; if (m_amp_hi !== 220) begin errors++; $display("FAIL m2_amp: got %0d required 220", m_amp_hi); end
      checks++; if (m_v1 !== 4)       begin errors++; $display("FAIL m2_vgroups: got %0d required 4", m_v1); end
      checks++; if (m_h1_hi !== 100)  begin errors++; $display("FAIL m2_h1_high: got %0d required 100", m_h1_hi); end
   endtask

   task automatic test_mode3_bin2();
      run_frame(2'd3, 3'd2, 3'd2, 3);
      checks++; if (m_busy !== 92)    begin errors++; $display("FAIL b22_busy: got %0d required 92", m_busy); end
      checks++; if (m_pv !== 6)       begin errors++; $display("FAIL b22_pix_valid: got %0d required 6", m_pv); end
      checks++; if (m_pos_err !== 0)  begin errors++; $display("FAIL b22_coords: got %0d bad required 0", m_pos_err); end
      checks++; if (m_end_y !== 2)    begin errors++; $display("FAIL b22_lines: got %0d required 2", m_end_y); end
      checks++; if (m_h1_rise !== 12) begin errors++; $display("FAIL b22_h1_pulses: got %0d required 12", m_h1_rise); end
      checks++; if (m_h1_hi !== 36)   begin errors++; $display("FAIL b22_h1_high: got %0d required 36", m_h1_hi); end
      checks++; if (m_v1 !== 4)       begin errors++; $display("FAIL b22_vgroups: got %0d required 4", m_v1); end
      checks++; if (m_fd !== 1)       begin errors++; $display("FAIL b22_frame_done: got %0d required 1", m_fd); end
   endtask

   task automatic test_mode1_clean();
      run_frame(2'd1, 3'd3, 3'd3, 5);
      checks++; if (m_busy !== 220)   begin errors++; $display("FAIL clean_busy: got %0d required 220", m_busy); end
      checks++; if (m_pv !== 0)       begin errors++; $display("FAIL clean_pix_valid: got %0d required 0", m_pv); end
      checks++; if (m_oeb_low !== 0)  begin errors++; $display("FAIL clean_oeb: got %0d low cycles required 0", m_oeb_low); end
      checks++; if (m_amp_hi !== 0)   begin errors++; $display("FAIL clean_amp: got %0d high cycles required 0", m_amp_hi); end
      checks++; if (m_r !== 20)       begin errors++; $display("FAIL clean_kaf_r: got %0d required 20", m_r); end
      checks++; if (m_fd !== 1)       begin errors++; $display("FAIL clean_frame_done: got %0d required 1", m_fd); end
   endtask

   task automatic test_mode3_vbin7();
      run_frame(2'd3, 3'd0, 3'd7, 5);
      checks++; if (m_busy !== 85)    begin errors++; $display("FAIL v7_busy: got %0d required 85", m_busy); end
      checks++; if (m_pv !== 5)       begin errors++; $display("FAIL v7_pix_valid: got %0d required 5", m_pv); end
      checks++; if (m_pos_err !== 0)  begin errors++; $display("FAIL v7_coords: got %0d bad required 0", m_pos_err); end
      checks++; if (m_end_y !== 1)    begin errors++; $display("FAIL v7_lines: got %0d required 1", m_end_y); end
      checks++; if (m_v1 !== 7)       begin errors++; $display("FAIL v7_vgroups: got %0d required 7", m_v1); end
      checks++; if (m_h1_rise !== 5)  begin errors++; $display("FAIL v7_h1_pulses: got %0d required 5", m_h1_rise); end
      checks++; if (m_fd !== 1)       begin errors++; $display("FAIL v7_frame_done: got %0d required 1", m_fd); end
   endtask

   task automatic test_abort();
      int fd;
      fd = 0;
      mode = 2'd2; hbin = 3'd0; vbin = 3'd0; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (29) @(negedge clk);
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_pre_busy: got %b required 1", busy); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      checks++;
      if (busy !== 1'b0 || frame_done !== 1'b0) begin
         errors++;
         $display("FAIL abort_idle: got busy=%b done=%b required 0 0", busy, frame_done);
      end
      repeat (5) begin
         @(negedge clk);
         if (frame_done) fd++;
      end
      checks++;
      if (fd !== 0) begin errors++; $display("FAIL abort_no_done: got %0d pulses required 0", fd); end
      start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b1) begin errors++; $display("FAIL abort_restart: got busy=%b required 1", busy); end
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      // abort together with start in IDLE keeps the block idle
      start = 1'b1; abort = 1'b1;
      @(negedge clk);
      start = 1'b0; abort = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL abort_start_idle: got busy=%b required 0", busy); end
   endtask

   task automatic test_rst_and_ignored_start();
      int fd;
      fd = 0;
      // Reset in the middle of a pixel (cycle 12 is P6)
      mode = 2'd2; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      repeat (11) @(negedge clk);
      checks++;
      if (ad_cdsclk2 !== 1'b1 || busy !== 1'b1) begin
         errors++;
         $display("FAIL rst_pre_state: got cds2=%b busy=%b required 1 1", ad_cdsclk2, busy);
      end
      #1 rst = 1'b1;
      #1;
      checks++;
      if ({ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n, kaf_r, kaf_h1, kaf_v1,
           kaf_v2, kaf_amp, busy, pix_valid, frame_done} !== 12'b0011_0000_0000) begin
         errors++;
         $display("FAIL rst_async_outputs: got %b required 001100000000",
                  {ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n, kaf_r, kaf_h1, kaf_v1,
                   kaf_v2, kaf_amp, busy, pix_valid, frame_done});
      end
      @(negedge clk);
      rst = 1'b0;
      repeat (3) begin
         @(negedge clk);
         if (frame_done) fd++;
      end
      checks++;
      if (fd !== 0) begin errors++; $display("FAIL rst_no_done: got %0d pulses required 0", fd); end
      // New mode-2 frame; start held with mode=1 while busy must not restart it
      mode = 2'd2; start = 1'b1;
      @(negedge clk);
      mode = 2'd1;
      repeat (5) @(negedge clk);
      checks++;
      if ({kaf_r, kaf_amp, busy} !== 3'b111) begin
         errors++;
         $display("FAIL start_while_busy: got r/amp/busy=%b required 111", {kaf_r, kaf_amp, busy});
      end
      start = 1'b0;
      abort = 1'b1;
      @(negedge clk);
      abort = 1'b0;
      // start with mode 0 is ignored
      mode = 2'd0; start = 1'b1;
      repeat (3) @(negedge clk);
      start = 1'b0;
      checks++;
      if (busy !== 1'b0) begin errors++; $display("FAIL start_mode0: got busy=%b required 0", busy); end
   endtask

   initial begin
      test_reset();
      test_mode2();
      test_mode3_bin2();
      test_mode1_clean();
      test_mode3_vbin7();
      test_abort();
      test_rst_and_ignored_start();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/ccd_readout_seq.md
CCD_READOUT_SEQ -- requirements
Module: ccd_readout_seq

Interface
REQ-001 Parameter H_REGS, default 2184: horizontal CCD pixels per line.
REQ-002 Parameter V_REGS, default 1472: vertical CCD lines per frame.
REQ-003 Parameter CW, default 12: width of the pixel/line counters and coordinate outputs; H_REGS and V_REGS SHALL each be below 2^CW.
REQ-004 Ports SHALL be, clock and reset first:
- clk, in, 1: sequencer clock, one state per rising edge; a divided counter bit supplied by the parent.
- rst, in, 1: reset, asynchronous and active-high.
- start, in, 1: sampled in IDLE only; starts a frame.
- abort, in, 1: ends any frame.
- mode, in, 2: 0 = idle, 1 = clean, 2 = readout 1x1, 3 = readout binned.
- hbin, in, 3: horizontal bin factor.
- vbin, in, 3: vertical bin factor.
- ad_cdsclk1, ad_cdsclk2, ad_adclk, ad_oeb_n, out, 1 each: AFE controls.
- kaf_r, kaf_h1, kaf_v1, kaf_v2, kaf_amp, out, 1 each: CCD clocks.
- busy, out, 1: frame in progress.
- pix_valid, out, 1: binned-pixel strobe.
- pix_x, pix_y, out, CW each: binned coordinates of the pixel marked by pix_valid.
- frame_done, out, 1: frame completion pulse.

Function
REQ-005 All state and registered outputs SHALL update on rising clk; CCD and AFE outputs SHALL be decoded combinationally from the state.
REQ-006 In IDLE, with start=1 and mode!=0, the block SHALL latch mode, hbin and vbin and enter V0 on the next edge; start in any other state SHALL be ignored.
REQ-007 Latched bin factor 0 SHALL be treated as 1; mode 1 and mode 2 SHALL force both factors to 1.
REQ-008 Define HB and VB as the effective horizontal and vertical bin factors, NP = ceil(H_REGS/HB) pixels per line, and NL = ceil(V_REGS/VB) lines per frame.
REQ-009 Each line SHALL be VB vertical groups followed by NP pixels; a frame SHALL be NL lines.
REQ-010 Vertical group, 5 states, decoded outputs:
- V0: adclk, oeb_n.
- V1: adclk, oeb_n, v2.
- V2: adclk, oeb_n, v1.
- V3: adclk, oeb_n, v2.
- V4: adclk, oeb_n.
REQ-011 Pixel states and decoded outputs:
- P0: adclk, r, h1.
- P1: adclk, h1.
- P2: cdsclk1, h1.
- P3: h1.
- P4: h1.
- P5: none.
- X1/X0 pairs, HB-1 times, inserted after P5: X1 drives h1, X0 drives none.
- P6: cdsclk2.
- P7: adclk, cdsclk2.
- P8: adclk, cdsclk2.
- P9: adclk.
REQ-012 Cycle counts: pixel = 10 + 2*(HB-1) cycles; vertical group = 5 cycles.
REQ-013 Any output not listed for the current state SHALL be 0.
REQ-014 In mode 1 (clean), ad_oeb_n SHALL be 1 in every state and pix_valid SHALL never assert.
REQ-015 kaf_amp SHALL be 1 in every non-IDLE state of modes 2 and 3, and 0 otherwise.
REQ-016 In modes 2 and 3, pix_valid SHALL be 1 for exactly the P9 cycle of each pixel.
REQ-017 During the pix_valid cycle, pix_x SHALL equal the pixel index (0..NP-1) and pix_y the line index (0..NL-1).
REQ-018 Transitions:
- V4 SHALL go to V0 until VB groups are done, then to P0.
- P9 SHALL go to P0 until NP pixels are done.
- After the last pixel, P9 SHALL go to V0 for the next line, or to IDLE after line NL-1.
REQ-019 The horizontal pixel counter SHALL reset at the start of each line; the line counter SHALL reset on entry from IDLE.
REQ-020 frame_done SHALL be a one-cycle pulse in the first IDLE cycle after a completed frame.
REQ-021 busy SHALL be 1 in every non-IDLE state and 0 in IDLE.
REQ-022 abort=1 SHALL force IDLE on the next edge from any state without pulsing frame_done; abort takes priority over all transitions.
REQ-023 If abort and start are both 1 in IDLE, the block SHALL stay in IDLE.
REQ-024 IDLE outputs SHALL be ad_adclk=1 and ad_oeb_n=1, with all other outputs 0.

Reset
REQ-025 rst=1 SHALL immediately force IDLE, clear all counters and latched configuration, and hold busy, pix_valid and frame_done at 0, with IDLE outputs per REQ-024.
REQ-026 Reset asserted mid-frame SHALL abandon the frame with no frame_done; after rst falls, the block SHALL accept start.

Verification
REQ-027 The bench SHALL use H_REGS=5, V_REGS=4 and cover:
- Mode 2 start -> busy high for 220 cycles; 20 pix_valid pulses scanning x 0..4 within y 0..3; frame_done once; kaf_r high 20 cycles.
- Mode 3, hbin=2, vbin=2 -> 92 busy cycles; 6 pix_valid pulses (x 0..2, y 0..1); 1 X1 h1 pulse per pixel; 2 vertical groups per line.
- Mode 1 -> 220 busy cycles; 0 pix_valid; ad_oeb_n=1 and kaf_amp=0 throughout; frame_done once.
- Mode 3, hbin=0, vbin=7 -> hbin treated as 1; NL=1; 5 pixels; 7 vertical groups; 85 busy cycles.
- Abort at cycle 30 of a mode 2 frame -> IDLE the next cycle; no frame_done; a new start accepted.
- Async rst mid-pixel -> outputs show the IDLE pattern before the next clk edge; start while busy, and start with mode=0 -> ignored.
